// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  // Largest value held by a units digit and by a tens digit of MM:SS.
  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  // 50 MHz / 2^19 is roughly 95 divider ticks per second.
  localparam int TICKS_PER_SEC_DEF = 95;

endpackage

// File: rtl/edge_sync.sv
// Three-flop synchroniser for an asynchronous level, with rising-edge detect.
module edge_sync
  import stopwatch_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  // Re-time din; s3 holds the previous synchronised level for edge detection.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
      s3 <= RESET_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: synchronised buttons and tick drive an idle/run/pause/lap
// FSM, a tick prescaler, a BCD MM:SS counter and a lap capture register.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [15:0] disp_time,
  output logic [1:0]  state,
  output logic        running,
  output logic        sec_pulse
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

  logic tick_ev, start_ev, lap_ev, clear_ev;

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q;
  logic [15:0]       time_q;
  logic [15:0]       lap_q;
  logic              sec_pulse_q;

  logic counting, inc, idle_entry, capture;

  // Advance MM:SS by one second, wrapping 59:59 to 00:00.
  function automatic logic [15:0] bcd_time_inc(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so == ONES_MAX) begin
      so = 4'd0;
      if (st == TENS_MAX) begin
        st = 4'd0;
        if (mo == ONES_MAX) begin
          mo = 4'd0;
          mt = (mt == TENS_MAX) ? 4'd0 : mt + 4'd1;
        end else begin
          mo = mo + 4'd1;
        end
      end else begin
        st = st + 4'd1;
      end
    end else begin
      so = so + 4'd1;
    end
    return {mt, mo, st, so};
  endfunction

  // Buttons reset high so a button held through reset release gives no event.
  edge_sync #(.RESET_VAL(1'b0)) u_sync_tick  (.clock(clock), .rst(rst), .din(tick_in),   .rise(tick_ev));
  edge_sync #(.RESET_VAL(1'b1)) u_sync_start (.clock(clock), .rst(rst), .din(btn_start), .rise(start_ev));
  edge_sync #(.RESET_VAL(1'b1)) u_sync_lap   (.clock(clock), .rst(rst), .din(btn_lap),   .rise(lap_ev));
  edge_sync #(.RESET_VAL(1'b1)) u_sync_clear (.clock(clock), .rst(rst), .din(btn_clear), .rise(clear_ev));

  // Ticks count only in RUN/LAP, judged on the current state, so a tick that
  // coincides with start is counted when leaving RUN but not when leaving PAUSE.
  assign counting   = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign inc        = counting && tick_ev && (pre_q == PRE_MAX);
  assign idle_entry = (state_q != ST_IDLE) && (state_d == ST_IDLE);
  assign capture    = (state_q == ST_RUN) && (state_d == ST_LAP);

  // Next-state logic; earlier checks win when events coincide.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ev) state_d = ST_RUN;
      ST_RUN: begin
        if (start_ev)    state_d = ST_PAUSE;
        else if (lap_ev) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (start_ev)    state_d = ST_PAUSE;
        else if (lap_ev) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (clear_ev)      state_d = ST_IDLE;
        else if (start_ev) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Prescaler: held in PAUSE, cleared in IDLE and on the way into it.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else if (idle_entry || (state_q == ST_IDLE)) begin
      pre_q <= '0;
    end else if (counting && tick_ev) begin
      pre_q <= (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
    end
  end

  // Live time counter and its one-cycle increment pulse.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      time_q      <= 16'h0000;
      sec_pulse_q <= 1'b0;
    end else begin
      sec_pulse_q <= inc;
      if (idle_entry)  time_q <= 16'h0000;
      else if (inc)    time_q <= bcd_time_inc(time_q);
    end
  end

  // Lap capture takes the pre-increment time when a tick lands on the same edge.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)            lap_q <= 16'h0000;
    else if (idle_entry) lap_q <= 16'h0000;
    else if (capture)    lap_q <= time_q;
  end

  assign state     = state_q;
  assign running   = counting;
  assign sec_pulse = sec_pulse_q;
  assign disp_time = (state_q == ST_LAP) ? lap_q : time_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a two-tick-per-second prescaler.
module tb_stopwatch_ctrl;

  logic        clock = 1'b0;
  logic        rst;
  logic        tick_in;
  logic        btn_start;
  logic        btn_lap;
  logic        btn_clear;
  logic [15:0] disp_time;
  logic [1:0]  state;
  logic        running;
  logic        sec_pulse;

  int vectors     = 0;
  int miscompares = 0;
  int pulse_cnt   = 0;
  int p0;

  stopwatch_ctrl #(.TICKS_PER_SEC(2)) dut (
    .clock     (clock),
    .rst       (rst),
    .tick_in   (tick_in),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .btn_clear (btn_clear),
    .disp_time (disp_time),
    .state     (state),
    .running   (running),
    .sec_pulse (sec_pulse)
  );

  always #5 clock = ~clock;

  // Count one-second pulses, sampled on the inactive edge.
  always @(negedge clock) begin
    if (sec_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise the selected inputs together for two clocks, then drop them for two;
  // every resulting update has landed when this returns.
  task automatic pulse_in(input bit s, input bit l, input bit c, input bit t);
    btn_start = s;
    btn_lap   = l;
    btn_clear = c;
    tick_in   = t;
    repeat (2) step();
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    tick_in   = 1'b0;
    repeat (2) step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse_in(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst       = 1'b0;
    tick_in   = 1'b0;
    btn_start = 1'b1;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    repeat (3) step();
    check("rst_state",   32'(state),     32'h0);
    check("rst_disp",    32'(disp_time), 32'h0000);
    check("rst_running", 32'(running),   32'h0);
    check("rst_pulse",   32'(sec_pulse), 32'h0);

    // Start held through reset release must not start the watch.
    rst = 1'b1;
    repeat (5) step();
    check("held_start_state", 32'(state),     32'h0);
    check("held_start_disp",  32'(disp_time), 32'h0000);
    btn_start = 1'b0;
    repeat (4) step();
    check("release_state", 32'(state), 32'h0);

    // Run up to 00:12, lap, let live time run to 00:15 underneath.
    p0 = pulse_cnt;
    pulse_in(1'b1, 1'b0, 1'b0, 1'b0);
    check("start_state",   32'(state),   32'h1);
    check("start_running", 32'(running), 32'h1);
    ticks(1);
    check("first_tick_disp", 32'(disp_time), 32'h0000);
    ticks(1);
    check("second_tick_disp", 32'(disp_time), 32'h0001);
    check("second_tick_pulses", 32'(pulse_cnt - p0), 32'd1);
    ticks(22);
    check("run_0012", 32'(disp_time), 32'h0012);
    pulse_in(1'b0, 1'b1, 1'b0, 1'b0);
    check("lap_state", 32'(state),     32'h3);
    check("lap_disp",  32'(disp_time), 32'h0012);
    check("lap_running", 32'(running), 32'h1);
    ticks(6);
    check("lap_frozen", 32'(disp_time), 32'h0012);
    pulse_in(1'b0, 1'b1, 1'b0, 1'b0);
    check("unlap_state", 32'(state),     32'h1);
    check("unlap_disp",  32'(disp_time), 32'h0015);
    ticks(90);
    check("one_minute_disp",   32'(disp_time),        32'h0100);
    check("one_minute_pulses", 32'(pulse_cnt - p0),   32'd60);

    // Lap together with the incrementing tick captures the old time.
    ticks(1);
    pulse_in(1'b0, 1'b1, 1'b0, 1'b1);
    check("lap_tick_state", 32'(state),     32'h3);
    check("lap_tick_disp",  32'(disp_time), 32'h0100);
    pulse_in(1'b0, 1'b1, 1'b0, 1'b0);
    check("lap_tick_live", 32'(disp_time), 32'h0101);

    // Clear has no effect while running.
    pulse_in(1'b0, 1'b0, 1'b1, 1'b0);
    check("clear_in_run", 32'(state), 32'h1);

    // Climb to 59:59 and wrap.
    ticks(7076);
    check("disp_5959", 32'(disp_time), 32'h5959);
    ticks(1);
    check("disp_5959_half", 32'(disp_time), 32'h5959);
    tick_in = 1'b1;
    repeat (2) step();
    tick_in = 1'b0;
    step();
    check("wrap_disp",  32'(disp_time), 32'h0000);
    check("wrap_pulse", 32'(sec_pulse), 32'h1);
    step();

    // Ticks during PAUSE and together with start-from-PAUSE are dropped.
    ticks(1);
    pulse_in(1'b1, 1'b0, 1'b0, 1'b0);
    check("pause_state",   32'(state),   32'h2);
    check("pause_running", 32'(running), 32'h0);
    ticks(1);
    check("pause_tick_disp", 32'(disp_time), 32'h0000);
    pulse_in(1'b1, 1'b0, 1'b0, 1'b1);
    check("resume_state", 32'(state),     32'h1);
    check("resume_disp",  32'(disp_time), 32'h0000);
    ticks(1);
    check("resume_tick_disp", 32'(disp_time), 32'h0001);

    // Clear beats start in PAUSE and zeroes time and prescaler.
    ticks(1);
    pulse_in(1'b1, 1'b0, 1'b0, 1'b0);
    pulse_in(1'b1, 1'b0, 1'b1, 1'b0);
    check("clear_state", 32'(state),     32'h0);
    check("clear_disp",  32'(disp_time), 32'h0000);
    pulse_in(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1);
    check("cleared_pre_disp", 32'(disp_time), 32'h0000);
    ticks(1);
    check("cleared_sec_disp", 32'(disp_time), 32'h0001);

    // Asynchronous reset mid-run clears everything immediately.
    ticks(452);
    check("disp_0347", 32'(disp_time), 32'h0347);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_state",   32'(state),     32'h0);
    check("async_rst_disp",    32'(disp_time), 32'h0000);
    check("async_rst_running", 32'(running),   32'h0);
    check("async_rst_pulse",   32'(sec_pulse), 32'h0);
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    pulse_in(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_state", 32'(state),     32'h1);
    check("restart_disp",  32'(disp_time), 32'h0000);
    ticks(2);
    check("restart_tick_disp", 32'(disp_time), 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
